// File: rtl/sha3_pkg.sv
// Shared SHA-3 types and constants for the absorb path: mode encoding, rates
// and padding bytes, plus the lane layout the Keccak core consumes.
`timescale 1ns/1ps
package sha3_pkg;

   typedef enum logic [1:0] {
      SHA3_224 = 2'd0,
      SHA3_256 = 2'd1,
      SHA3_384 = 2'd2,
      SHA3_512 = 2'd3
   } sha3_mode_e;

   // Rate in 16-bit words for each mode, indexed by the mode encoding.
   localparam logic [6:0] RATE_WORDS [4] = '{7'd72, 7'd68, 7'd52, 7'd36};

   localparam logic [7:0] PAD_DOMAIN = 8'h06;
   localparam logic [7:0] PAD_FINAL  = 8'h80;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      PAD  = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef logic [4:0][4:0][63:0] keccak_state_t;

   function automatic logic [7:0] rate_bytes(input logic [1:0] mode);
      return {RATE_WORDS[mode], 1'b0};
   endfunction

endpackage

// File: rtl/sha3_pad_packer.sv
// Packs a 16-bit message stream little-endian into Keccak rate blocks,
// applies SHA-3 padding on the final beat and hands blocks over with valid/ready.
`timescale 1ns/1ps
module sha3_pad_packer
   import sha3_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [DATA_WIDTH-1:0] s_TDATA,
   input  logic [1:0]            s_TKEEP,
   input  logic                  s_TVALID,
   input  logic                  s_TLAST,
   input  logic [1:0]            s_TUSER,
   output logic                  s_TREADY,
   output keccak_state_t         blk_data,
   output logic                  blk_valid,
   output logic                  blk_last,
   input  logic                  blk_ready,
   output logic [1:0]            blk_mode
);

   state_t          state;
   logic [1599:0]   buffer;
   logic [6:0]      wcnt;
   logic [7:0]      pad_pos;
   logic            pad_pend;
   logic            armed;

   logic [1:0]            beat_mode;
   logic [7:0]            beat_rate;
   logic [7:0]            valid_bytes;
   logic [7:0]            pad_pos_next;
   logic [DATA_WIDTH-1:0] beat_word;
   logic [7:0]            final_idx;
   logic [1599:0]         pad_mask;

   assign blk_data = buffer;

   // The first beat of a message uses TUSER directly; later beats use the latch.
   assign beat_mode = armed ? s_TUSER : blk_mode;
   assign beat_rate = rate_bytes(beat_mode);

   // Only the TLAST beat may be short; every other keep pattern counts as two bytes.
   always_comb begin
      valid_bytes = 8'd2;
      beat_word   = s_TDATA;
      if (s_TLAST && s_TKEEP == 2'b01) begin
         valid_bytes = 8'd1;
         beat_word   = {8'h00, s_TDATA[7:0]};
      end else if (s_TLAST && s_TKEEP == 2'b00) begin
         valid_bytes = 8'd0;
         beat_word   = '0;
      end
   end

   assign pad_pos_next = {wcnt, 1'b0} + valid_bytes;
   assign final_idx    = rate_bytes(blk_mode) - 8'd1;
   assign pad_mask     = (1600'(PAD_DOMAIN) << {pad_pos, 3'b000})
                       ^ (1600'(PAD_FINAL) << {final_idx, 3'b000});

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state     <= FILL;
         buffer    <= '0;
         wcnt      <= '0;
         pad_pos   <= '0;
         pad_pend  <= 1'b0;
         armed     <= 1'b1;
         s_TREADY  <= 1'b0;
         blk_valid <= 1'b0;
         blk_last  <= 1'b0;
         blk_mode  <= '0;
      end else begin
         case (state)
            FILL: begin
               if (!s_TREADY) begin
                  s_TREADY <= 1'b1;
               end else if (s_TVALID) begin
                  if (armed) begin
                     blk_mode <= s_TUSER;
                     armed    <= 1'b0;
                  end
                  buffer[{wcnt, 4'b0000} +: DATA_WIDTH] <= beat_word;
                  wcnt <= wcnt + 7'd1;
                  if (s_TLAST) begin
                     pad_pos  <= pad_pos_next;
                     s_TREADY <= 1'b0;
                     // An exactly full block goes out first; padding follows in a block of its own.
                     if (pad_pos_next == beat_rate) begin
                        state     <= HOLD;
                        blk_valid <= 1'b1;
                        blk_last  <= 1'b0;
                        pad_pend  <= 1'b1;
                     end else begin
                        state <= PAD;
                     end
                  end else if (wcnt + 7'd1 == RATE_WORDS[beat_mode]) begin
                     state     <= HOLD;
                     s_TREADY  <= 1'b0;
                     blk_valid <= 1'b1;
                     blk_last  <= 1'b0;
                  end
               end
            end
            PAD: begin
               buffer    <= buffer ^ pad_mask;
               state     <= HOLD;
               blk_valid <= 1'b1;
               blk_last  <= 1'b1;
            end
            HOLD: begin
               if (blk_ready) begin
                  buffer    <= '0;
                  wcnt      <= '0;
                  blk_valid <= 1'b0;
                  blk_last  <= 1'b0;
                  if (pad_pend) begin
                     state    <= PAD;
                     pad_pos  <= '0;
                     pad_pend <= 1'b0;
                  end else begin
                     state    <= FILL;
                     s_TREADY <= 1'b1;
                     if (blk_last) armed <= 1'b1;
                  end
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_sha3_pad_packer.sv
// Scoreboard bench for sha3_pad_packer: a byte-level SHA-3 padding model queues
// the expected blocks per message and a monitor checks each block on transfer.
`timescale 1ns/1ps
module tb_sha3_pad_packer;
   import sha3_pkg::*;

   typedef struct {
      logic [1599:0] data;
      logic          last;
      logic [1:0]    mode;
   } expBlock_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [15:0]   sTdata = '0;
   logic [1:0]    sTkeep = '0;
   logic          sTvalid = 1'b0;
   logic          sTlast = 1'b0;
   logic [1:0]    sTuser = '0;
   logic          sTready;
   keccak_state_t blkData;
   logic          blkValid;
   logic          blkLast;
   logic          blkReady = 1'b0;
   logic [1:0]    blkMode;
   logic [1599:0] blkFlat;

   int            compared = 0;
   int            mismatched = 0;
   int            blockCount = 0;
   int            readyMode = 0;
   expBlock_t     expQ[$];
   logic [7:0]    msgBytes[$];

   logic          prevHeld = 1'b0;
   logic [1599:0] prevData;
   logic          prevLast;
   logic [1:0]    prevMode;

   assign blkFlat = blkData;

   always #5 clock = ~clock;

   sha3_pad_packer #(.DATA_WIDTH(16)) dut (
      .ACLK      (clock),
      .ARESET    (reset),
      .s_TDATA   (sTdata),
      .s_TKEEP   (sTkeep),
      .s_TVALID  (sTvalid),
      .s_TLAST   (sTlast),
      .s_TUSER   (sTuser),
      .s_TREADY  (sTready),
      .blk_data  (blkData),
      .blk_valid (blkValid),
      .blk_last  (blkLast),
      .blk_ready (blkReady),
      .blk_mode  (blkMode)
   );

   // Rate follows from the digest size: 200 state bytes minus twice the digest.
   function automatic int rateBytes(input logic [1:0] mode);
      int digestBits;
      case (mode)
         2'd0:    digestBits = 224;
         2'd1:    digestBits = 256;
         2'd2:    digestBits = 384;
         default: digestBits = 512;
      endcase
      return 200 - 2 * (digestBits / 8);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Pad the whole message as SHA-3 does and cut it into rate-sized blocks.
   task automatic pushExpected(input logic [1:0] mode);
      int         len;
      int         rb;
      int         nblk;
      logic [7:0] padded[];
      expBlock_t  e;
      len  = msgBytes.size();
      rb   = rateBytes(mode);
      nblk = len / rb + 1;
      padded = new[nblk * rb];
      foreach (padded[i]) padded[i] = 8'h00;
      for (int i = 0; i < len; i++) padded[i] = msgBytes[i];
      padded[len]          = padded[len] ^ 8'h06;
      padded[nblk * rb - 1] = padded[nblk * rb - 1] ^ 8'h80;
      for (int b = 0; b < nblk; b++) begin
         e.data = '0;
         for (int i = 0; i < rb; i++) e.data[8*i +: 8] = padded[b * rb + i];
         e.last = (b == nblk - 1);
         e.mode = mode;
         expQ.push_back(e);
      end
   endtask

   task automatic fillRandom(input int len);
      msgBytes.delete();
      for (int i = 0; i < len; i++) msgBytes.push_back(8'($urandom));
   endtask

   task automatic sendBeat(input logic [15:0] data, input logic [1:0] keep, input logic last, input logic [1:0] user);
      int waited;
      waited = 0;
      @(negedge clock);
      sTdata  = data;
      sTkeep  = keep;
      sTlast  = last;
      sTuser  = user;
      sTvalid = 1'b1;
      while (!sTready) begin
         @(negedge clock);
         waited++;
         if (waited > 5000) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL beat_accept_timeout actual=stalled required=accepted");
            sTvalid = 1'b0;
            return;
         end
      end
      @(posedge clock);
      #1;
      sTvalid = 1'b0;
   endtask

   task automatic applyStimulus(input logic [1:0] mode, input bit keep00Term, input bit gaps);
      int len;
      int nWords;
      bit isLast;
      len    = msgBytes.size();
      nWords = len / 2;
      pushExpected(mode);
      if (len == 0) begin
         sendBeat(16'($urandom), 2'b00, 1'b1, mode);
      end else begin
         for (int w = 0; w < nWords; w++) begin
            isLast = (w == nWords - 1) && (len % 2 == 0) && !keep00Term;
            if (gaps && ($urandom_range(4, 0) == 0)) repeat ($urandom_range(2, 1)) @(negedge clock);
            sendBeat({msgBytes[2*w+1], msgBytes[2*w]}, isLast ? 2'b11 : 2'($urandom),
                     isLast, (w == 0) ? mode : 2'($urandom));
         end
         if (len % 2 == 1)
            sendBeat({8'($urandom), msgBytes[len-1]}, 2'b01, 1'b1, (nWords == 0) ? mode : 2'($urandom));
         else if (keep00Term)
            sendBeat(16'($urandom), 2'b00, 1'b1, 2'($urandom));
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while ((expQ.size() != 0 || blkValid) && waited < 6000) begin
         @(negedge clock);
         waited++;
      end
      if (expQ.size() != 0 || blkValid) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain_timeout pending=%0d required=0", expQ.size());
      end
   endtask

   // Keccak-side readiness: random, forced low or forced high.
   initial begin
      forever begin
         @(posedge clock);
         #2;
         case (readyMode)
            1:       blkReady = 1'b0;
            2:       blkReady = 1'b1;
            default: blkReady = ($urandom_range(3, 0) != 0);
         endcase
      end
   end

   // Monitor: invariants every cycle, scoreboard compare on each transfer.
   initial begin
      expBlock_t e;
      int        idx;
      forever begin
         @(negedge clock);
         if (reset) begin
            prevHeld = 1'b0;
         end else begin
            checkOutput("no_overlap", 32'(sTready & blkValid), 32'd0);
            if (prevHeld) begin
               compared++;
               if (!blkValid || blkFlat !== prevData || blkLast !== prevLast || blkMode !== prevMode) begin
                  mismatched++;
                  $display("[TB] FAIL hold_stable valid=%b last=%b/%b mode=%0d/%0d required unchanged",
                           blkValid, blkLast, prevLast, blkMode, prevMode);
               end
            end
            if (blkValid && blkReady) begin
               compared++;
               if (expQ.size() == 0) begin
                  mismatched++;
                  $display("[TB] FAIL unexpected_block index=%0d actual=block required=none", blockCount);
               end else begin
                  e = expQ.pop_front();
                  if (blkFlat !== e.data || blkLast !== e.last || blkMode !== e.mode) begin
                     idx = -1;
                     for (int i = 0; i < 200; i++) begin
                        if (blkFlat[8*i +: 8] !== e.data[8*i +: 8]) begin
                           idx = i;
                           break;
                        end
                     end
                     mismatched++;
                     $display("[TB] FAIL block_%0d byte %0d actual=%h expected=%h last actual=%b expected=%b mode actual=%0d expected=%0d",
                              blockCount, idx, (idx >= 0) ? blkFlat[8*idx +: 8] : 8'h00,
                              (idx >= 0) ? e.data[8*idx +: 8] : 8'h00, blkLast, e.last, blkMode, e.mode);
                  end
               end
               blockCount++;
            end
            prevHeld = blkValid && !blkReady;
            prevData = blkFlat;
            prevLast = blkLast;
            prevMode = blkMode;
         end
      end
   end

   initial begin
      logic [1599:0] captured;
      int            waited;

      // Reset values while ARESET is high, then ready one clock after release.
      repeat (3) @(negedge clock);
      checkOutput("reset_tready", 32'(sTready), 32'd0);
      checkOutput("reset_valid", 32'(blkValid), 32'd0);
      checkOutput("reset_last", 32'(blkLast), 32'd0);
      checkOutput("reset_mode", 32'(blkMode), 32'd0);
      checkOutput("reset_data_zero", 32'(blkFlat != '0), 32'd0);
      @(posedge clock);
      #3 reset = 1'b0;
      @(negedge clock);
      checkOutput("tready_before_clock", 32'(sTready), 32'd0);
      @(negedge clock);
      checkOutput("tready_after_clock", 32'(sTready), 32'd1);

      // Empty message, SHA3-256: one PAD cycle, then the padded block.
      readyMode = 1;
      fillRandom(0);
      applyStimulus(2'd1, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("empty_pad_cycle_valid", 32'(blkValid), 32'd0);
      @(negedge clock);
      checkOutput("empty_valid", 32'(blkValid), 32'd1);
      checkOutput("empty_last", 32'(blkLast), 32'd1);
      checkOutput("empty_byte0", 32'(blkFlat[7:0]), 32'h06);
      checkOutput("empty_byte135", 32'(blkFlat[135*8 +: 8]), 32'h80);
      checkOutput("empty_mode", 32'(blkMode), 32'd1);
      readyMode = 0;
      drain();

      msgBytes.delete();
      msgBytes.push_back(8'h61);
      msgBytes.push_back(8'h62);
      msgBytes.push_back(8'h63);
      applyStimulus(2'd1, 1'b0, 1'b0);
      drain();

      fillRandom(72);
      applyStimulus(2'd3, 1'b0, 1'b1);
      drain();

      fillRandom(143);
      applyStimulus(2'd0, 1'b0, 1'b1);
      drain();

      // Backpressure: block must hold steady and the stream must stay stalled.
      readyMode = 1;
      fillRandom(10);
      applyStimulus(2'd2, 1'b0, 1'b0);
      waited = 0;
      while (!blkValid && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("bp_valid", 32'(blkValid), 32'd1);
      captured = blkFlat;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         checkOutput("bp_data_stable", 32'(blkFlat !== captured), 32'd0);
         checkOutput("bp_tready_low", 32'(sTready), 32'd0);
      end
      readyMode = 2;
      waited = 0;
      while (blkValid && waited < 100) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("bp_tready_after_transfer", 32'(sTready), 32'd1);
      readyMode = 0;
      drain();

      // Reset in the middle of a SHA3-384 message: nothing may be emitted for it.
      for (int w = 0; w < 20; w++) sendBeat(16'($urandom), 2'b11, 1'b0, (w == 0) ? 2'd2 : 2'($urandom));
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      checkOutput("midreset_tready", 32'(sTready), 32'd0);
      checkOutput("midreset_valid", 32'(blkValid), 32'd0);
      repeat (2) @(negedge clock);
      @(posedge clock);
      #3 reset = 1'b0;
      fillRandom(2);
      applyStimulus(2'd1, 1'b0, 1'b0);
      drain();

      for (int m = 0; m < 30; m++) begin
         fillRandom($urandom_range(260, 0));
         applyStimulus(2'($urandom), ($urandom_range(2, 0) == 0), 1'b1);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sha3_pad_packer.md
# sha3_pad_packer

Upstream absorb stage for the Keccak core: accepts the 16-bit AXI-Stream message and packs it little-endian into a 1600-bit rate block. It applies SHA-3 padding (domain suffix 0x06, final 0x80) on TLAST for the rate selected by TUSER. Each full or padded block is presented to `keccak_xor` (Din / Din_valid / Last_block / Ready) with a valid/ready hold.

## Interface
- `DATA_WIDTH`, 16, stream word width; only 16 is supported.
- `ACLK` in 1: clock, rising edge.
- `ARESET` in 1: **asynchronous, active-high reset**.
- `s_TDATA` in 16: message bytes; byte0 = [7:0].
- `s_TKEEP` in 2: byte enables.
- `s_TVALID` in 1: beat valid.
- `s_TLAST` in 1: final beat of message.
- `s_TUSER` in 2: mode: 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512.
- `s_TREADY` out 1: beat accepted when `s_TVALID & s_TREADY`.
- `blk_data` out [4:0][4:0][63:0]: block to Keccak; capacity lanes are zero.
- `blk_valid` out 1: block valid, held until accepted.
- `blk_last` out 1: final block of message, qualified by `blk_valid`.
- `blk_ready` in 1: Keccak ready; a block transfers when `blk_valid & blk_ready`.
- `blk_mode` out 2: latched mode of the current message.

## Operation
- Rate in words, R: mode 0/1/2/3 gives 72/68/52/36; rate in bytes is 2R.
- **Mode latch:** mode latches on the first beat of each message. `s_TUSER` on later beats is ignored.
- **Word placement:** word k of a block lands at bits [16(k%4)+15 : 16(k%4)] of lane L = k/4. Lane L maps to `blk_data[L/5][L%5]`.
- **Word counter:** `wcnt`, 7 bits.
- **Beat rules:**
  - Non-last beats must have TKEEP=11.
  - The TLAST beat may have TKEEP 11, 01 or 00; 00 means zero bytes.
  - Illegal TKEEP is treated as 11.
- **Pad position:** p = 2·wcnt + valid bytes of the last beat.
- **States:**
  - FILL: `s_TREADY`=1. Store beat, wcnt++.
    - wcnt reaches R on a non-last beat → HOLD, `blk_last`=0.
    - TLAST with p < 2R → PAD.
    - TLAST with p = 2R → HOLD with `blk_last`=0 and `pad_pend`=1.
  - PAD: one cycle. XOR 0x06 into byte p and 0x80 into byte 2R−1; if p = 2R−1 that byte becomes 0x86. Then → HOLD, `blk_last`=1.
  - HOLD: `blk_valid`=1 and `s_TREADY`=0. On `blk_ready`, clear buffer and wcnt, then:
    - `pad_pend` set → PAD with p=0, clear `pad_pend`.
    - else → FILL; if `blk_last` was set, the mode latch re-arms.
- Unused buffer bytes are zero; the buffer is cleared on every transfer.

## Timing
- **Reset values:** `s_TREADY`=0 while ARESET is high, then 1 on the first clock after release (state FILL). `blk_valid`=0, `blk_last`=0, `blk_data`=0, `blk_mode`=0.
- **Latency, full block:** non-last beat filling the block accepted at edge t → `blk_valid` from t+1.
- **Latency, last beat:** TLAST beat at t → `blk_valid` from t+2 (one PAD cycle).
- **Exact-fill message:** the full block is valid at t+1. After its transfer at edge u, PAD runs at u+1 and the pad-only block is valid from u+2.
- **Back-to-back:** `blk_valid`, `blk_data`, `blk_last` and `blk_mode` are stable while `blk_ready`=0. After a transfer, `s_TREADY` returns the next cycle (non-pending case).
- **No overlap:** `s_TREADY` and `blk_valid` are never both 1.
- **Reset mid-message:** partial block and `pad_pend` are discarded; no block is emitted.

## Structure
- **Package `sha3_pkg`:**
  - `sha3_mode_e` enum.
  - `RATE_WORDS[4]` constant array.
  - `PAD_DOMAIN`=8'h06, `PAD_FINAL`=8'h80.
  - `state_t` {FILL, PAD, HOLD}.
  - Lane typedef `keccak_state_t` = logic [4:0][4:0][63:0], shared with `keccak_xor`.
- **Sub-modules:** none required; the buffer is written through a byte-index decode inside the block.

## Test plan
- **Empty message, mode 1:** single beat TLAST, TKEEP=00 → one block, `blk_last`=1. byte0=0x06, byte135=0x80, all else 0. `blk_valid` 2 cycles after the beat.
- **"abc", mode 1:** beats 16'h6261 (keep 11), 16'h0063 (keep 01, TLAST) → bytes 0..3 = 61 62 63 06, byte135=0x80.
- **Exact fill, mode 3:** 36 beats ending in TLAST (keep 11) → block 1 is full data with `blk_last`=0. Block 2 after its transfer: byte0=0x06, byte71=0x80, `blk_last`=1.
- **Odd fill, mode 0:** 72 words where the last beat has keep 01 and TLAST → byte143 = 0x86, single block with `blk_last`=1.
- **Backpressure:** hold `blk_ready`=0 for 10 cycles → `blk_data` stable and `s_TREADY`=0 throughout. Transfer on release; `s_TREADY`=1 the next cycle.
- **Reset mid-message:** ARESET asserted after 20 beats in mode 2 → outputs reset immediately. A following 2-byte message produces a block containing only those 2 bytes plus padding.
